ysyx_24110006_wbu: RTL and testbench
====================================

YSYX_24110006_WBU -- requirements
Module: ysyx_24110006_WBU

Interface
REQ-001 SHALL have ports (name, direction, width, meaning):
- i_clock  in  1  sole clock; all state updates on its rising edge.
- i_reset  in  1  synchronous, active-low reset.
- i_valid  in  1  LSU result valid.
- o_ready  out  1  WBU accepts a result.
- i_pc  in  32  PC of the instruction.
- i_upc  in  32  sequential next PC; used only for the retire trace.
- i_reg_wen  in  1  GPR write request.
- i_reg_rd  in  5  destination GPR.
- i_result  in  32  GPR write data; rs1 source data for CSR ops.
- i_csr_t  in  2  00 none, 01 CSRRW, 10 CSRRS, 11 MRET.
- i_csr  in  12  CSR address.
- i_exception  in  1  instruction trapped.
- i_mcause  in  4  trap cause.
- o_rf_wen  out  1  GPR write strobe.
- o_rf_waddr  out  5  GPR write address.
- o_rf_wdata  out  32  GPR write data.
- o_flush  out  1  pipeline flush and redirect.
- o_redirect_pc  out  32  redirect target.
- o_retire  out  1  one instruction retired this cycle.
- o_retire_pc  out  32  PC of the retired instruction.
- o_mtvec  out  32  current mtvec, for the IFU.
REQ-002 SHALL define a transfer as i_valid && o_ready on a rising edge of i_clock.

Function
REQ-003 SHALL drive o_ready = 1 whenever i_reset = 1.
REQ-004 SHALL implement these CSRs; all other addresses read 0 and ignore writes:
- mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342: read/write.
- mcycle 0xB00 / mcycleh 0xB80: read-only.
- minstret 0xB02 / minstreth 0xB82: read-only.
- mvendorid 0xF11 = 0x79737978: read-only constant.
- marchid 0xF12 = 0x016FE3B6: read-only constant.
REQ-005 SHALL drive the GPR write combinationally in the transfer cycle:
- o_rf_wen = transfer && i_reg_wen && !i_exception && i_reg_rd != 0 && !o_flush.
- o_rf_waddr = i_reg_rd.
REQ-006 SHALL select o_rf_wdata:
- CSR value read before the update when i_csr_t is 01 or 10.
- i_result otherwise.
REQ-007 SHALL update the addressed CSR at the edge ending a non-exception, non-flush transfer:
- CSRRW: CSR <= i_result.
- CSRRS: CSR <= old | i_result.
- CSRRS with i_result = 0 SHALL leave the CSR unchanged.
REQ-008 SHALL handle a transfer with i_exception = 1:
- mepc <= i_pc.
- mcause <= {28'b0, i_mcause}.
- No GPR or CSR-op write.
- Next cycle: o_flush = 1 and o_redirect_pc = mtvec value at the trap edge.
REQ-009 SHALL handle a transfer with i_csr_t = 11 (MRET): next cycle o_flush = 1 and o_redirect_pc = mepc.
REQ-010 SHALL keep o_flush as a single-cycle registered pulse.
REQ-011 SHALL discard any transfer completing while o_flush = 1: no GPR write, no CSR update, no retire, no new flush.
REQ-012 SHALL increment the 64-bit mcycle every cycle out of reset, wrapping 0xFFFFFFFF_FFFFFFFF -> 0.
REQ-013 SHALL increment the 64-bit minstret by 1 per retired instruction, wrapping the same way.
REQ-014 SHALL count as retired every non-discarded, non-exception transfer, including MRET.
REQ-015 SHALL pulse o_retire and o_retire_pc combinationally in the retire cycle.
REQ-016 SHALL return the pre-increment value for a CSR read of mcycle or minstret in the same cycle.
REQ-017 SHALL apply a trap and cancel a CSR write in the same instruction when i_exception = 1 and i_csr_t != 00; the trap wins.
REQ-018 SHALL let a trap's mepc/mcause write override a CSRRW to mepc/mcause in the same instruction.
REQ-019 SHALL drive o_mtvec continuously from the mtvec register.

Reset
REQ-020 SHALL apply, while i_reset = 0 at a clock edge:
- mstatus = 0x00001800.
- mtvec, mepc, mcause, mcycle, minstret = 0.
- o_flush = 0, o_redirect_pc = 0.
- o_ready = 0.
REQ-021 SHALL force o_rf_wen = 0 and o_retire = 0 while i_reset = 0.
REQ-022 SHALL drop, without side effects, an instruction presented in the cycle reset asserts.
REQ-023 SHALL leave a pending flush pulse cleared by reset.

Verification
REQ-024 SHALL cover these directed scenarios:
- ADDI retire, rd=5, i_result=0x1234 -> o_rf_wen=1, waddr=5, wdata=0x1234, o_retire=1, minstret +1.
- Write to x0, rd=0, i_reg_wen=1 -> o_rf_wen=0, o_retire=1.
- CSRRW 0x305, i_result=0x80000100, rd=3 -> x3 gets old mtvec 0; next cycle o_mtvec=0x80000100.
- CSRRS 0x300, i_result=0x8, rd=4 -> x4=0x1800; mstatus=0x1808.
- Exception, pc=0x80000010, mcause=11, mtvec=0x80000100 -> mepc=0x80000010, mcause=11, no retire; next cycle o_flush=1, o_redirect_pc=0x80000100; instruction arriving that cycle discarded.
- MRET with mepc=0x80000014 -> next cycle o_flush=1, o_redirect_pc=0x80000014.
- Reset mid-stream -> all CSRs at reset values; mcycle restarts from 0 after release.

Source files
------------

// File: rtl/ysyx_24110006_wbu.sv
// rtl/ysyx_24110006_wbu.sv - write-back unit: GPR write, CSR file, trap/MRET redirect, retire counters
module ysyx_24110006_wbu (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_upc,
  input  logic        i_reg_wen,
  input  logic [4:0]  i_reg_rd,
  input  logic [31:0] i_result,
  input  logic [1:0]  i_csr_t,
  input  logic [11:0] i_csr,
  input  logic        i_exception,
  input  logic [3:0]  i_mcause,
  output logic        o_rf_wen,
  output logic [4:0]  o_rf_waddr,
  output logic [31:0] o_rf_wdata,
  output logic        o_flush,
  output logic [31:0] o_redirect_pc,
  output logic        o_retire,
  output logic [31:0] o_retire_pc,
  output logic [31:0] o_mtvec
);

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;

  localparam logic [1:0] OP_CSRRW = 2'b01;
  localparam logic [1:0] OP_CSRRS = 2'b10;
  localparam logic [1:0] OP_MRET  = 2'b11;

  logic [31:0] mstatus;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic [31:0] mcause;
  logic [63:0] mcycle;
  logic [63:0] minstret;

  logic        transfer;
  logic        active;
  logic        trap;
  logic        retire;
  logic        csr_op;
  logic        is_mret;
  logic [31:0] csr_rdata;
  logic [31:0] csr_wdata;
  logic        unused_upc;

  assign unused_upc = ^i_upc;

  assign o_ready  = i_reset;
  assign transfer = i_valid && o_ready;
  // A transfer landing in the flush cycle belongs to the squashed path.
  assign active   = transfer && !o_flush;
  assign trap     = active && i_exception;
  assign retire   = active && !i_exception;
  assign csr_op   = retire && (i_csr_t == OP_CSRRW || i_csr_t == OP_CSRRS);
  assign is_mret  = retire && (i_csr_t == OP_MRET);

  always_comb begin
    csr_rdata = 32'h0;
    case (i_csr)
      CSR_MSTATUS:   csr_rdata = mstatus;
      CSR_MTVEC:     csr_rdata = mtvec;
      CSR_MEPC:      csr_rdata = mepc;
      CSR_MCAUSE:    csr_rdata = mcause;
      CSR_MCYCLE:    csr_rdata = mcycle[31:0];
      CSR_MCYCLEH:   csr_rdata = mcycle[63:32];
      CSR_MINSTRET:  csr_rdata = minstret[31:0];
      CSR_MINSTRETH: csr_rdata = minstret[63:32];
      CSR_MVENDORID: csr_rdata = 32'h79737978;
      CSR_MARCHID:   csr_rdata = 32'h016FE3B6;
      default:       csr_rdata = 32'h0;
    endcase
  end

  assign csr_wdata = (i_csr_t == OP_CSRRW) ? i_result : (csr_rdata | i_result);

  assign o_rf_wen    = transfer && i_reg_wen && !i_exception && (i_reg_rd != 5'd0) && !o_flush;
  assign o_rf_waddr  = i_reg_rd;
  assign o_rf_wdata  = (i_csr_t == OP_CSRRW || i_csr_t == OP_CSRRS) ? csr_rdata : i_result;
  assign o_retire    = retire;
  assign o_retire_pc = i_pc;
  assign o_mtvec     = mtvec;

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      mstatus       <= 32'h00001800;
      mtvec         <= 32'h0;
      mepc          <= 32'h0;
      mcause        <= 32'h0;
      mcycle        <= 64'h0;
      minstret      <= 64'h0;
      o_flush       <= 1'b0;
      o_redirect_pc <= 32'h0;
    end else begin
      mcycle  <= mcycle + 64'd1;
      o_flush <= trap || is_mret;
      if (retire) minstret <= minstret + 64'd1;
      if (trap) o_redirect_pc <= mtvec;
      else if (is_mret) o_redirect_pc <= mepc;
      if (csr_op) begin
        case (i_csr)
          CSR_MSTATUS: mstatus <= csr_wdata;
          CSR_MTVEC:   mtvec   <= csr_wdata;
          CSR_MEPC:    mepc    <= csr_wdata;
          CSR_MCAUSE:  mcause  <= csr_wdata;
          default: ;
        endcase
      end
      // Trap state is written last so it takes priority over any CSR op.
      if (trap) begin
        mepc   <= i_pc;
        mcause <= {28'b0, i_mcause};
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24110006_wbu.sv
// tb/tb_ysyx_24110006_wbu.sv - directed scoreboard bench for the write-back unit
module tb_ysyx_24110006_wbu;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_pc;
  logic [31:0] i_upc;
  logic        i_reg_wen;
  logic [4:0]  i_reg_rd;
  logic [31:0] i_result;
  logic [1:0]  i_csr_t;
  logic [11:0] i_csr;
  logic        i_exception;
  logic [3:0]  i_mcause;
  logic        o_rf_wen;
  logic [4:0]  o_rf_waddr;
  logic [31:0] o_rf_wdata;
  logic        o_flush;
  logic [31:0] o_redirect_pc;
  logic        o_retire;
  logic [31:0] o_retire_pc;
  logic [31:0] o_mtvec;

  always #5 i_clock = ~i_clock;

  ysyx_24110006_wbu dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_pc(i_pc), .i_upc(i_upc), .i_reg_wen(i_reg_wen), .i_reg_rd(i_reg_rd),
    .i_result(i_result), .i_csr_t(i_csr_t), .i_csr(i_csr), .i_exception(i_exception),
    .i_mcause(i_mcause), .o_rf_wen(o_rf_wen), .o_rf_waddr(o_rf_waddr),
    .o_rf_wdata(o_rf_wdata), .o_flush(o_flush), .o_redirect_pc(o_redirect_pc),
    .o_retire(o_retire), .o_retire_pc(o_retire_pc), .o_mtvec(o_mtvec)
  );

  typedef struct {
    string       tag;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        retire;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  int          pass_cnt = 0;
  int          fail_cnt = 0;
  int          total    = 0;
  logic [63:0] cyc      = 64'd0;
  logic [31:0] pc_r     = 32'h80000000;

  // Reference cycle counter: zero through reset, +1 on every edge afterwards.
  always @(posedge i_clock) cyc <= i_reset ? cyc + 64'd1 : 64'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    i_valid = 1'b0; i_reg_wen = 1'b0; i_reg_rd = 5'd0; i_result = 32'h0;
    i_csr_t = 2'b00; i_csr = 12'h0; i_exception = 1'b0; i_mcause = 4'd0;
  endtask

  task automatic advance();
    @(posedge i_clock);
    #1;
  endtask

  task automatic op(input string tag, input logic reg_wen, input logic [4:0] rd,
                    input logic [31:0] result, input logic [1:0] csr_t, input logic [11:0] csr,
                    input logic exc, input logic [3:0] mc,
                    input logic e_wen, input logic [31:0] e_wdata, input logic e_ret);
    exp_t e;
    i_valid = 1'b1; i_pc = pc_r; i_upc = pc_r + 32'd4; i_reg_wen = reg_wen; i_reg_rd = rd;
    i_result = result; i_csr_t = csr_t; i_csr = csr; i_exception = exc; i_mcause = mc;
    e.tag = tag; e.wen = e_wen; e.waddr = rd; e.wdata = e_wdata; e.retire = e_ret; e.pc = pc_r;
    sb.push_back(e);
    pc_r = pc_r + 32'd4;
    @(negedge i_clock);
    e = sb.pop_front();
    chk({e.tag, ".wen"}, 64'(o_rf_wen), 64'(e.wen));
    chk({e.tag, ".retire"}, 64'(o_retire), 64'(e.retire));
    if (e.wen) begin
      chk({e.tag, ".waddr"}, 64'(o_rf_waddr), 64'(e.waddr));
      chk({e.tag, ".wdata"}, 64'(o_rf_wdata), 64'(e.wdata));
    end
    if (e.retire) chk({e.tag, ".retire_pc"}, 64'(o_retire_pc), 64'(e.pc));
    advance();
    idle();
  endtask

  task automatic rd_csr(input string tag, input logic [11:0] csr, input logic [31:0] e_val);
    op(tag, 1'b1, 5'd1, 32'h0, 2'b10, csr, 1'b0, 4'd0, 1'b1, e_val, 1'b1);
  endtask

  initial begin
    i_pc = 32'h0; i_upc = 32'h0;
    idle();
    i_reset = 1'b0;
    // An instruction presented during reset must be dropped.
    i_valid = 1'b1; i_reg_wen = 1'b1; i_reg_rd = 5'd5; i_result = 32'h77;
    advance();
    advance();
    chk("rst.ready", 64'(o_ready), 64'd0);
    chk("rst.rf_wen", 64'(o_rf_wen), 64'd0);
    chk("rst.retire", 64'(o_retire), 64'd0);
    chk("rst.flush", 64'(o_flush), 64'd0);
    chk("rst.redirect", 64'(o_redirect_pc), 64'd0);
    chk("rst.mtvec", 64'(o_mtvec), 64'd0);
    idle();
    i_reset = 1'b1;
    #1;
    chk("run.ready", 64'(o_ready), 64'd1);

    rd_csr("mcycle0", 12'hB00, cyc[31:0]);
    rd_csr("minstret1", 12'hB02, 32'd1);
    op("addi", 1'b1, 5'd5, 32'h1234, 2'b00, 12'h0, 1'b0, 4'd0, 1'b1, 32'h1234, 1'b1);
    rd_csr("minstret3", 12'hB02, 32'd3);
    op("x0", 1'b1, 5'd0, 32'h99, 2'b00, 12'h0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b1);
    op("csrrw_mtvec", 1'b1, 5'd3, 32'h80000100, 2'b01, 12'h305, 1'b0, 4'd0, 1'b1, 32'h0, 1'b1);
    chk("o_mtvec", 64'(o_mtvec), 64'h80000100);
    op("csrrs_mstatus", 1'b1, 5'd4, 32'h8, 2'b10, 12'h300, 1'b0, 4'd0, 1'b1, 32'h1800, 1'b1);
    rd_csr("mstatus", 12'h300, 32'h1808);

    // Trap carrying a CSRRW to mepc: the trap must win.
    pc_r = 32'h80000010;
    op("trap", 1'b1, 5'd8, 32'hDEAD, 2'b01, 12'h341, 1'b1, 4'd11, 1'b0, 32'h0, 1'b0);
    chk("trap.flush", 64'(o_flush), 64'd1);
    chk("trap.redirect", 64'(o_redirect_pc), 64'h80000100);
    op("discard", 1'b1, 5'd6, 32'h55, 2'b01, 12'h305, 1'b0, 4'd0, 1'b0, 32'h0, 1'b0);
    chk("flush.pulse", 64'(o_flush), 64'd0);
    chk("discard.mtvec", 64'(o_mtvec), 64'h80000100);
    rd_csr("mepc", 12'h341, 32'h80000010);
    rd_csr("mcause", 12'h342, 32'd11);

    op("csrrw_mepc", 1'b1, 5'd7, 32'h80000014, 2'b01, 12'h341, 1'b0, 4'd0, 1'b1, 32'h80000010, 1'b1);
    op("mret", 1'b0, 5'd0, 32'h0, 2'b11, 12'h0, 1'b0, 4'd0, 1'b0, 32'h0, 1'b1);
    chk("mret.flush", 64'(o_flush), 64'd1);
    chk("mret.redirect", 64'(o_redirect_pc), 64'h80000014);
    advance();
    chk("mret.pulse", 64'(o_flush), 64'd0);
    rd_csr("minstret12", 12'hB02, 32'd12);

    rd_csr("mvendorid", 12'hF11, 32'h79737978);
    rd_csr("marchid", 12'hF12, 32'h016FE3B6);
    rd_csr("unmapped", 12'h123, 32'h0);
    op("wr_ro", 1'b0, 5'd0, 32'hFFFFFFFF, 2'b01, 12'hF11, 1'b0, 4'd0, 1'b0, 32'h0, 1'b1);
    rd_csr("mvendorid_ro", 12'hF11, 32'h79737978);
    rd_csr("mcycle", 12'hB00, cyc[31:0]);
    rd_csr("mcycleh", 12'hB80, cyc[63:32]);

    // Reset while a trap flush is pending.
    pc_r = 32'h80000040;
    op("trap2", 1'b0, 5'd0, 32'h0, 2'b00, 12'h0, 1'b1, 4'd2, 1'b0, 32'h0, 1'b0);
    chk("trap2.flush", 64'(o_flush), 64'd1);
    i_reset = 1'b0;
    advance();
    chk("rst2.flush", 64'(o_flush), 64'd0);
    chk("rst2.mtvec", 64'(o_mtvec), 64'd0);
    advance();
    i_reset = 1'b1;
    rd_csr("rst2.mcycle", 12'hB00, 32'd0);
    rd_csr("rst2.mtvec_rd", 12'h305, 32'h0);
    rd_csr("rst2.mstatus", 12'h300, 32'h1800);
    rd_csr("rst2.mepc", 12'h341, 32'h0);
    rd_csr("rst2.mcause", 12'h342, 32'h0);
    rd_csr("rst2.minstret", 12'hB02, 32'd5);
    rd_csr("rst2.mcycle_run", 12'hB00, cyc[31:0]);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
